// File: rtl/risc32_exc_ctrl_pkg.sv
// Shared constants and types for the exception/interrupt commit unit.
package risc32_exc_ctrl_pkg;

    // ExcCode values written into Cause.ExcCode
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_TR   = 5'd13;

    // Bit positions inside exc_flags_i
    localparam int EXC_FLAG_RI_ADELF = 0;
    localparam int EXC_FLAG_SYS      = 1;
    localparam int EXC_FLAG_BP       = 2;
    localparam int EXC_FLAG_TR       = 3;
    localparam int EXC_FLAG_OV       = 4;
    localparam int EXC_FLAG_ADES     = 5;
    localparam int EXC_FLAG_ADEL_D   = 6;
    localparam int EXC_FLAG_ERET     = 7;

    // CP0 register addresses seen on the WB bypass path
    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;

    typedef enum logic [1:0] {
        EXC_ST_IDLE  = 2'd0,
        EXC_ST_FLUSH = 2'd1,
        EXC_ST_BLOCK = 2'd2
    } exc_state_t;

endpackage

// File: rtl/risc32_exc_prio.sv
// Combinational priority encoder: picks the winning event among the
// pending interrupt and the MEM-stage exception flags.
module risc32_exc_prio
    import risc32_exc_ctrl_pkg::*;
(
    input  logic [7:0] flags,
    input  logic       int_pending,
    input  logic       pc_misaligned,
    output logic       valid,
    output logic       is_eret,
    output logic [4:0] code
);

    // Fixed priority chain; interrupt beats every synchronous exception,
    // eret only wins when nothing else is raised.
    always_comb begin
        valid   = 1'b1;
        is_eret = 1'b0;
        code    = EXC_INT;
        if (int_pending)
            code = EXC_INT;
        else if (flags[EXC_FLAG_RI_ADELF])
            code = pc_misaligned ? EXC_ADEL : EXC_RI;
        else if (flags[EXC_FLAG_SYS])
            code = EXC_SYS;
        else if (flags[EXC_FLAG_BP])
            code = EXC_BP;
        else if (flags[EXC_FLAG_TR])
            code = EXC_TR;
        else if (flags[EXC_FLAG_OV])
            code = EXC_OV;
        else if (flags[EXC_FLAG_ADEL_D])
            code = EXC_ADEL;
        else if (flags[EXC_FLAG_ADES])
            code = EXC_ADES;
        else if (flags[EXC_FLAG_ERET])
            is_eret = 1'b1;
        else
            valid = 1'b0;
    end

endmodule

// File: rtl/risc32_exc_ctrl.sv
// Exception/interrupt commit unit between MEM and CP0.
//
// state | meaning
// IDLE  | accepting events from MEM
// FLUSH | commit cycle: flush and strobe outputs are high
// BLOCK | wrong-path window, all inputs ignored until counter expires
module risc32_exc_ctrl
    import risc32_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int          BLOCK_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid_i,
    input  logic [31:0] pc_i,
    input  logic        in_delay_slot_i,
    input  logic [7:0]  exc_flags_i,
    input  logic [31:0] bad_vaddr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        exc_commit_o,
    output logic [4:0]  exc_code_o,
    output logic [31:0] exc_epc_o,
    output logic        exc_bd_o,
    output logic [31:0] exc_badvaddr_o,
    output logic        eret_commit_o
);

    exc_state_t  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] eff_status, eff_cause, eff_epc;
    logic        int_pending, pc_misaligned, fetch_adel;
    logic        ev_valid, ev_eret, take;
    logic [4:0]  ev_code;
    logic        unused_bits;

    // WB mtc0 bypass so an in-flight CP0 write is honoured this cycle
    always_comb begin
        eff_status = status_i;
        eff_cause  = cause_i;
        eff_epc    = epc_i;
        if (wb_cp0_we_i) begin
            if (wb_cp0_waddr_i == CP0_REG_STATUS)
                eff_status = wb_cp0_data_i;
            if (wb_cp0_waddr_i == CP0_REG_EPC)
                eff_epc = wb_cp0_data_i;
            if (wb_cp0_waddr_i == CP0_REG_CAUSE) begin
                eff_cause[9:8] = wb_cp0_data_i[9:8];
                eff_cause[23]  = wb_cp0_data_i[23];
                eff_cause[22]  = wb_cp0_data_i[22];
            end
        end
    end

    assign int_pending   = eff_status[0] & ~eff_status[1]
                         & (|(eff_cause[15:8] & eff_status[15:8]));
    assign pc_misaligned = |pc_i[1:0];
    assign unused_bits   = ^{eff_status[31:16], eff_status[7:2],
                             eff_cause[31:16], eff_cause[7:0]};

    risc32_exc_prio u_prio (
        .flags         (exc_flags_i),
        .int_pending   (int_pending),
        .pc_misaligned (pc_misaligned),
        .valid         (ev_valid),
        .is_eret       (ev_eret),
        .code          (ev_code)
    );

    assign take       = (state_q == EXC_ST_IDLE) & instr_valid_i & ev_valid;
    assign fetch_adel = (ev_code == EXC_ADEL) & exc_flags_i[EXC_FLAG_RI_ADELF]
                      & pc_misaligned;

    // State and block-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EXC_ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; BLOCK lasts exactly BLOCK_CYCLES cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            EXC_ST_IDLE: begin
                if (take)
                    state_d = EXC_ST_FLUSH;
            end
            EXC_ST_FLUSH: begin
                state_d = EXC_ST_BLOCK;
                cnt_d   = 3'(BLOCK_CYCLES);
            end
            EXC_ST_BLOCK: begin
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = EXC_ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = EXC_ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Registered commit outputs; record fields hold until the next commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_o        <= 1'b0;
            new_pc_o       <= 32'd0;
            exc_commit_o   <= 1'b0;
            exc_code_o     <= 5'd0;
            exc_epc_o      <= 32'd0;
            exc_bd_o       <= 1'b0;
            exc_badvaddr_o <= 32'd0;
            eret_commit_o  <= 1'b0;
        end else begin
            flush_o       <= take;
            exc_commit_o  <= take & ~ev_eret;
            eret_commit_o <= take & ev_eret;
            if (take) begin
                if (ev_eret) begin
                    new_pc_o <= eff_epc;
                end else begin
                    new_pc_o       <= EXC_VECTOR;
                    exc_code_o     <= ev_code;
                    exc_epc_o      <= in_delay_slot_i ? (pc_i - 32'd4) : pc_i;
                    exc_bd_o       <= in_delay_slot_i;
                    exc_badvaddr_o <= fetch_adel ? pc_i : bad_vaddr_i;
                end
            end
        end
    end

endmodule
